// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, issues one instruction-memory request at a time and
// presents the registered instruction word (with its PC) to decode.
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned_fault
);

    // Handshakes: a request transfers on a cycle where imem_req_valid && imem_req_ready;
    // a response is taken only in S_WAIT when imem_rsp_valid is high; decode consumes
    // instr on any cycle where instr_valid && !stall.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              kill_q, kill_d;
    logic              instr_valid_q, instr_valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [XLEN-1:0]   instr_pc_q, instr_pc_d;
    logic              fault_q, fault_d;

    logic redirect_ok;
    logic redirect_bad;

    assign redirect_ok  = redirect_valid && (redirect_target[1:0] == 2'b00);
    assign redirect_bad = redirect_valid && (redirect_target[1:0] != 2'b00);

    // Any redirect, even a rejected misaligned one, blocks a new request that cycle.
    assign imem_req_valid   = rst_n && (state_q == S_REQ) && !redirect_valid;
    assign imem_addr        = pc_q;
    assign instr_valid      = instr_valid_q;
    assign instr            = instr_q;
    assign instr_pc         = instr_pc_q;
    assign pc_plus4         = instr_pc_q + XLEN'(4);
    assign misaligned_fault = fault_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        kill_d        = kill_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        fault_d       = redirect_bad;

        if (redirect_ok) begin
            pc_d          = redirect_target;
            instr_valid_d = 1'b0;
            case (state_q)
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end
                S_OUT:   state_d = S_REQ;
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_req_valid && imem_req_ready) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            instr_d       = imem_rsp_data;
                            instr_pc_d    = pc_q;
                            instr_valid_d = 1'b1;
                            pc_d          = pc_q + XLEN'(4);
                            state_d       = S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (!stall) begin
                        instr_valid_d = 1'b0;
                        state_d       = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            kill_q        <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= NOP;
            instr_pc_q    <= '0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            kill_q        <= kill_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            fault_q       <= fault_d;
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the RISC-V core. Holds the PC and fetches one 32-bit instruction at a time through a valid/ready instruction-memory port.
- Presents a registered instruction word to decode. That word drives the opcode decoder and the imm_instruction input of extend_immediate.
- Accepts a redirect (branch/jump target computed from imm_extended) from downstream.

Parameters:
- XLEN, 32 (riscv_pkg::XLEN): PC and address width.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_addr  output  XLEN  fetch address (current PC)
- imem_rsp_valid  input  1  response data valid
- imem_rsp_data  input  32  fetched instruction word
- stall  input  1  decode cannot consume instr this cycle
- redirect_valid  input  1  taken branch/jump
- redirect_target  input  XLEN  new PC (PC+imm_extended or ALU result)
- instr_valid  output  1  instr/instr_pc valid for decode
- instr  output  32  instruction to decode / extend_immediate
- instr_pc  output  XLEN  address of instr
- pc_plus4  output  XLEN  instr_pc+4 (link value for JAL/JALR)
- misaligned_fault  output  1  one-cycle pulse: redirect_target[1:0]!=0

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=REQ, kill=0.
  - instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=0, misaligned_fault=0.
  - imem_req_valid=0 while rst_n=0.
- At most one outstanding memory request. rsp_valid is sampled only in WAIT and ignored in all other states.
- imem_req_valid = (state==REQ) && !redirect_valid, combinational. imem_addr = pc.
- State REQ: on imem_req_valid && imem_req_ready, go to WAIT.
- State WAIT, on imem_rsp_valid:
  - If kill=1: discard the data, clear kill, go to REQ.
  - Else: instr<=imem_rsp_data, instr_pc<=pc, instr_valid<=1, pc<=pc+4, go to OUT.
- State OUT: instr_valid=1, instr held stable. When !stall (consumed this cycle): instr_valid<=0, go to REQ.
- Minimum throughput: 3 cycles per instruction with 1-cycle memory latency (REQ, WAIT, OUT).
- pc_plus4 = instr_pc+4, combinational.
- All PC arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC+4 = 0.
- Redirect (redirect_valid=1, target[1:0]==0) has priority over every other event in the same cycle. pc<=redirect_target, instr_valid<=0, then by state:
  - REQ: stay in REQ. No handshake occurs, since imem_req_valid is forced low.
  - WAIT with no rsp this cycle: kill<=1, stay in WAIT.
  - WAIT with rsp this cycle: discard the response, go to REQ.
  - OUT: go to REQ, dropping instr regardless of stall.
- Misaligned redirect (redirect_target[1:0]!=0):
  - misaligned_fault=1 for the next cycle only.
  - Redirect ignored entirely; state, pc and instr unaffected.
  - imem_req_valid is still forced low that cycle.
- stall has no effect outside OUT. A response arriving in WAIT is captured even if stall=1.
- Reset mid-operation aborts any in-flight request. A late rsp_valid after reset is ignored because state=REQ.
- instr_valid, instr, instr_pc and misaligned_fault are registered outputs.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT -> immediately instr_valid=0, instr=32'h13, imem_req_valid=0. After release, first request has imem_addr=RESET_PC=0.
- Sequential fetch: memory returns 32'h00500093, 32'h00a00113, 32'h002081b3 one cycle after each accepted request, stall=0 -> instr_valid pulses with instr_pc 0,4,8 and pc_plus4 4,8,12. Spacing is 3 cycles.
- Stall: stall=1 for 5 cycles while instr=32'h00a00113 in OUT -> instr/instr_pc (4) held constant, no imem_req_valid. Next request has addr=8 one cycle after stall drops.
- Redirect in WAIT: redirect_target=32'h100 while the response for addr 8 is pending; memory returns 32'hDEADBEEF -> word discarded, instr_valid stays 0. Next request addr=32'h100.
- Misaligned redirect: redirect_target=32'h102 in OUT -> misaligned_fault=1 for one cycle, instr unchanged. Fetch continues sequentially at pc+4.
- Wrap: RESET_PC=32'hFFFF_FFFC, one fetch -> instr_pc=32'hFFFF_FFFC, pc_plus4=0, next imem_addr=0.
